// File: rtl/patch2x2_gen.sv
// patch2x2_gen: turns a raster 8-bit pixel stream into 2x2 neighbourhood
// patches {P(y+1,x+1), P(y,x+1), P(y+1,x), P(y,x)} for the bilinear resize.
// One source line is kept in a line buffer; the right edge is replicated so
// every patch row carries sourceImageWidth patches.
module patch2x2_gen #(
    parameter logic [11:0] sourceImageWidth = 12'd640,
    parameter logic [11:0] sourceImgHeight  = 12'd480
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_pix,
    input  logic        i_pix_valid,
    input  logic        i_sof,
    output logic [31:0] o_data,
    output logic        o_data_valid,
    output logic        o_patch_sol,
    output logic        o_patch_eof,
    output logic        o_frame_err
);

    localparam int          WIDTH    = int'(sourceImageWidth);
    localparam int          ADDR_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [11:0] COL_LAST = sourceImageWidth - 12'd1;
    localparam logic [11:0] ROW_LAST = sourceImgHeight - 12'd1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM
    } state_t;

    state_t            state;
    logic [11:0]       col;
    logic [11:0]       row;
    logic [7:0]        line_buf [0:WIDTH-1];
    logic [7:0]        up_pix;
    logic [7:0]        prev_cur;
    logic [7:0]        prev_up;
    logic              edge_pending;
    logic              edge_last;
    logic              sof_take;
    logic              pix_take;
    logic              restart;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    // Qualify the incoming pixel and pick line-buffer addresses; a start of
    // frame always lands at column 0 no matter where the counters were.
    always_comb begin
        sof_take = i_pix_valid & i_sof;
        pix_take = i_pix_valid & ((state != IDLE) | i_sof);
        restart  = sof_take & (state != IDLE);
        rd_addr  = col[ADDR_W-1:0];
        wr_addr  = sof_take ? '0 : col[ADDR_W-1:0];
        up_pix   = line_buf[rd_addr];
    end

    // Line buffer, read-before-write: the pixel above is read combinationally
    // at the current column while the new pixel replaces it on the clock edge.
    always_ff @(posedge i_clk) begin
        if (pix_take) begin
            line_buf[wr_addr] <= i_pix;
        end
    end

    // Frame sequencer: counters, pixel history, patch assembly and flags.
    // The right-edge beat is deferred one cycle through edge_pending; the
    // pixel after a row end is always column 0, which emits nothing, so the
    // two beat sources never coincide. The FSM drops to IDLE as soon as the
    // last pixel of the frame is taken so that a directly following start
    // of frame is legal, while the pending final edge beat still drains.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            prev_cur     <= '0;
            prev_up      <= '0;
            edge_pending <= 1'b0;
            edge_last    <= 1'b0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_patch_sol  <= 1'b0;
            o_patch_eof  <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_patch_sol  <= 1'b0;
            o_patch_eof  <= 1'b0;
            o_frame_err  <= 1'b0;
            edge_pending <= 1'b0;

            if (edge_pending && !restart) begin
                o_data       <= {prev_cur, prev_up, prev_cur, prev_up};
                o_data_valid <= 1'b1;
                o_patch_eof  <= edge_last;
            end

            if (pix_take) begin
                prev_cur <= i_pix;
                prev_up  <= up_pix;

                if (sof_take) begin
                    o_frame_err <= (state != IDLE);
                    edge_last   <= 1'b0;
                    col         <= 12'd1;
                    row         <= '0;
                    state       <= FILL;
                end else begin
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= (row == ROW_LAST) ? 12'd0 : row + 12'd1;
                    end else begin
                        col <= col + 12'd1;
                    end

                    case (state)
                        FILL: begin
                            if (col == COL_LAST) begin
                                state <= STREAM;
                            end
                        end
                        STREAM: begin
                            if (col != 12'd0) begin
                                o_data       <= {i_pix, up_pix, prev_cur, prev_up};
                                o_data_valid <= 1'b1;
                                o_patch_sol  <= (col == 12'd1);
                            end
                            if (col == COL_LAST) begin
                                edge_pending <= 1'b1;
                                edge_last    <= (row == ROW_LAST);
                                if (row == ROW_LAST) begin
                                    state <= IDLE;
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_patch2x2_gen.sv
// tb_patch2x2_gen: directed bench for patch2x2_gen with a 4x3 source frame,
// P(r,c) = base + 16r + c, and hand-computed patch values.
module tb_patch2x2_gen;

    localparam logic [11:0] W = 12'd4;
    localparam logic [11:0] H = 12'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pix;
    logic        pix_valid;
    logic        sof;
    logic [31:0] data;
    logic        data_valid;
    logic        patch_sol;
    logic        patch_eof;
    logic        frame_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] cap_data [$];
    bit          cap_sol  [$];
    bit          cap_eof  [$];
    int          cap_cyc  [$];
    int          err_pulses;
    int          pix_cyc [0:2][0:3];

    logic [31:0] exp_beats [0:7] = '{32'h11011000, 32'h12021101, 32'h13031202, 32'h13031303,
                                     32'h21112010, 32'h22122111, 32'h23132212, 32'h23132313};
    bit          exp_sol   [0:7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bit          exp_eof   [0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    patch2x2_gen #(
        .sourceImageWidth(W),
        .sourceImgHeight (H)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_pix       (pix),
        .i_pix_valid (pix_valid),
        .i_sof       (sof),
        .o_data      (data),
        .o_data_valid(data_valid),
        .o_patch_sol (patch_sol),
        .o_patch_eof (patch_eof),
        .o_frame_err (frame_err)
    );

    // Free-running clock and cycle stamp.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output beat and error pulse just after the clock edge.
    always @(posedge clk) begin
        #1;
        if (data_valid === 1'b1) begin
            cap_data.push_back(data);
            cap_sol.push_back(patch_sol);
            cap_eof.push_back(patch_eof);
            cap_cyc.push_back(cyc);
        end
        if (frame_err === 1'b1) err_pulses++;
    end

    function automatic logic [33:0] get_beat(input int k);
        if (k < cap_data.size()) return {cap_sol[k], cap_eof[k], cap_data[k]};
        return 34'hx;
    endfunction

    task automatic clear_capture();
        cap_data.delete();
        cap_sol.delete();
        cap_eof.delete();
        cap_cyc.delete();
        err_pulses = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_valid = 1'b0;
            sof       = 1'b0;
        end
    endtask

    task automatic send_pixel(input logic [7:0] p, input logic s);
        @(negedge clk);
        pix       = p;
        pix_valid = 1'b1;
        sof       = s;
    endtask

    // Pixels with raster index first..last, start of frame on index 0.
    task automatic send_range(input logic [7:0] base, input int first, input int last, input int gap);
        for (int idx = first; idx <= last; idx++) begin
            int r;
            int c;
            logic [7:0] p;
            r = idx / 4;
            c = idx % 4;
            p = base + 8'(16 * r + c);
            send_pixel(p, idx == 0);
            pix_cyc[r][c] = cyc;
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        pix       = '0;
        pix_valid = 1'b0;
        sof       = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", data_valid); end
        checks++;
        if (data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00000000", data); end
        checks++;
        if ({patch_sol, patch_eof, frame_err} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got sol/eof/err=%b expected 000", {patch_sol, patch_eof, frame_err});
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        clear_capture();
        send_range(8'h00, 0, 11, 0);
        idle(6);
        checks++;
        if (cap_data.size() !== 8) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 8", cap_data.size()); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (get_beat(k) !== {exp_sol[k], exp_eof[k], exp_beats[k]}) begin
                errors++;
                $display("[TB] FAIL basic_beat[%0d]: got %h expected %h", k, get_beat(k), {exp_sol[k], exp_eof[k], exp_beats[k]});
            end
        end
        checks++;
        if (cap_cyc.size() < 1 || cap_cyc[0] !== pix_cyc[1][1] + 1) begin
            errors++;
            $display("[TB] FAIL basic_first_cycle: got %0d expected %0d", (cap_cyc.size() > 0) ? cap_cyc[0] : -1, pix_cyc[1][1] + 1);
        end
        checks++;
        if (err_pulses !== 0) begin errors++; $display("[TB] FAIL basic_frame_err: got %0d expected 0", err_pulses); end
    endtask

    task automatic test_gaps();
        clear_capture();
        send_range(8'h00, 0, 11, 3);
        idle(6);
        checks++;
        if (cap_data.size() !== 8) begin errors++; $display("[TB] FAIL gaps_count: got %0d expected 8", cap_data.size()); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (get_beat(k) !== {exp_sol[k], exp_eof[k], exp_beats[k]}) begin
                errors++;
                $display("[TB] FAIL gaps_beat[%0d]: got %h expected %h", k, get_beat(k), {exp_sol[k], exp_eof[k], exp_beats[k]});
            end
        end
        checks++;
        if (cap_cyc.size() < 8 || cap_cyc[3] !== pix_cyc[1][3] + 2) begin
            errors++;
            $display("[TB] FAIL gaps_edge1_cycle: got %0d expected %0d", (cap_cyc.size() > 3) ? cap_cyc[3] : -1, pix_cyc[1][3] + 2);
        end
        checks++;
        if (cap_cyc.size() < 8 || cap_cyc[7] !== pix_cyc[2][3] + 2) begin
            errors++;
            $display("[TB] FAIL gaps_edge2_cycle: got %0d expected %0d", (cap_cyc.size() > 7) ? cap_cyc[7] : -1, pix_cyc[2][3] + 2);
        end
    endtask

    task automatic test_idle_ignore();
        clear_capture();
        for (int i = 0; i < 5; i++) send_pixel(8'h40 + 8'(i), 1'b0);
        idle(4);
        checks++;
        if (cap_data.size() !== 0 || err_pulses !== 0) begin
            errors++;
            $display("[TB] FAIL idle_ignore: got %0d beats %0d errs expected 0 0", cap_data.size(), err_pulses);
        end
        clear_capture();
        send_range(8'h00, 0, 11, 0);
        idle(6);
        checks++;
        if (cap_data.size() !== 8) begin errors++; $display("[TB] FAIL idle_frame_count: got %0d expected 8", cap_data.size()); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (get_beat(k) !== {exp_sol[k], exp_eof[k], exp_beats[k]}) begin
                errors++;
                $display("[TB] FAIL idle_frame_beat[%0d]: got %h expected %h", k, get_beat(k), {exp_sol[k], exp_eof[k], exp_beats[k]});
            end
        end
    endtask

    task automatic test_sof_mid();
        clear_capture();
        send_range(8'h00, 0, 5, 0);
        send_range(8'h80, 0, 11, 0);
        idle(6);
        checks++;
        if (err_pulses !== 1) begin errors++; $display("[TB] FAIL sofmid_err_pulses: got %0d expected 1", err_pulses); end
        checks++;
        if (cap_data.size() !== 9) begin errors++; $display("[TB] FAIL sofmid_count: got %0d expected 9", cap_data.size()); end
        checks++;
        if (get_beat(0) !== {2'b10, 32'h11011000}) begin
            errors++;
            $display("[TB] FAIL sofmid_old_beat: got %h expected %h", get_beat(0), {2'b10, 32'h11011000});
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (get_beat(k + 1) !== {exp_sol[k], exp_eof[k], exp_beats[k] + 32'h80808080}) begin
                errors++;
                $display("[TB] FAIL sofmid_beat[%0d]: got %h expected %h", k + 1, get_beat(k + 1),
                         {exp_sol[k], exp_eof[k], exp_beats[k] + 32'h80808080});
            end
        end
    endtask

    task automatic test_async_reset();
        clear_capture();
        send_range(8'h00, 0, 9, 0);
        @(posedge clk);
        #2;
        pix_valid = 1'b0;
        checks++;
        if (data_valid !== 1'b1 || data !== 32'h21112010) begin
            errors++;
            $display("[TB] FAIL areset_pre: got valid=%b data=%h expected 1 21112010", data_valid, data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({data_valid, patch_sol, patch_eof, frame_err} !== 4'b0000 || data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL areset_clear: got v/s/e/err=%b data=%h expected 0000 00000000",
                     {data_valid, patch_sol, patch_eof, frame_err}, data);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        clear_capture();
        send_range(8'h00, 0, 11, 0);
        idle(6);
        checks++;
        if (cap_data.size() !== 8) begin errors++; $display("[TB] FAIL areset_count: got %0d expected 8", cap_data.size()); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (get_beat(k) !== {exp_sol[k], exp_eof[k], exp_beats[k]}) begin
                errors++;
                $display("[TB] FAIL areset_beat[%0d]: got %h expected %h", k, get_beat(k), {exp_sol[k], exp_eof[k], exp_beats[k]});
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_capture();
        send_range(8'h00, 0, 11, 0);
        send_range(8'h00, 0, 11, 0);
        idle(6);
        checks++;
        if (err_pulses !== 0) begin errors++; $display("[TB] FAIL b2b_frame_err: got %0d expected 0", err_pulses); end
        checks++;
        if (cap_data.size() !== 16) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 16", cap_data.size()); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (get_beat(k) !== {exp_sol[k % 8], exp_eof[k % 8], exp_beats[k % 8]}) begin
                errors++;
                $display("[TB] FAIL b2b_beat[%0d]: got %h expected %h", k, get_beat(k),
                         {exp_sol[k % 8], exp_eof[k % 8], exp_beats[k % 8]});
            end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_idle_ignore();
        test_sof_mid();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
